// File: rtl/micro_rx_pkg.sv
// Shared types and defaults for the micro parallel-port receiver.
package micro_rx_pkg;

  localparam int unsigned H_ACTIVE_DEF = 480;
  localparam int unsigned V_ACTIVE_DEF = 272;

  typedef enum logic [7:0] {
    OP_NOP          = 8'h00,
    OP_SET_X        = 8'h01,
    OP_SET_Y        = 8'h02,
    OP_WRITE_PIXELS = 8'h03,
    OP_CLR_STATUS   = 8'h05
  } opcode_t;

  typedef enum logic [2:0] {
    StIdle,
    StCoordLo,
    StCoordHi,
    StPixR,
    StPixG,
    StPixB
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/micro_port_rx_if.sv
// Pixel write request channel: valid/ready handshake carrying coordinates and colour.
interface micro_port_rx_if #(
  parameter int unsigned COORD_W = 10
) ();

  logic               pix_wr_valid;
  logic               pix_wr_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [23:0]        pix_rgb;

  modport master (
    output pix_wr_valid,
    output pix_x,
    output pix_y,
    output pix_rgb,
    input  pix_wr_ready
  );

  modport slave (
    input  pix_wr_valid,
    input  pix_x,
    input  pix_y,
    input  pix_rgb,
    output pix_wr_ready
  );

endinterface

// File: rtl/micro_strobe_sync.sv
// Multi-flop synchronizer for the async {write, rsel, data} bus plus a registered
// rising-edge detector on the synchronized write strobe.
module micro_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write,
  input  logic       rsel,
  input  logic [7:0] data,
  output logic       byte_evt,
  output logic [7:0] byte_data,
  output logic       byte_rsel
);

  logic [9:0] sync_q [SYNC_STAGES];
  logic       write_prev_q;

  // Synchronizer chain; the whole bus moves together, bus hold time covers skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {write, rsel, data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Registered rising-edge pulse with the byte captured alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_prev_q <= 1'b0;
      byte_evt     <= 1'b0;
      byte_data    <= '0;
      byte_rsel    <= 1'b0;
    end else begin
      write_prev_q <= sync_q[SYNC_STAGES-1][9];
      byte_evt     <= sync_q[SYNC_STAGES-1][9] & ~write_prev_q;
      byte_rsel    <= sync_q[SYNC_STAGES-1][8];
      byte_data    <= sync_q[SYNC_STAGES-1][7:0];
    end
  end

endmodule

// File: rtl/micro_port_rx.sv
// Receiver for the microcontroller's 8-bit parallel port: decodes command/data bytes,
// keeps the X/Y cursor and emits one-deep buffered pixel write requests.
// Optional feature: define MICRO_RX_TIMEOUT_EN to abort stalled multi-byte sequences.
module micro_port_rx
  import micro_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned COORD_W     = 10
`ifdef MICRO_RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [7:0]            fpga_port_in,
  input  logic                  fpga_rsel,
  input  logic                  fpga_write,
  micro_port_rx_if.master       pix,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  ovf_err,
  output logic                  rx_activity
);

  localparam logic [COORD_W-1:0] XLast = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] YLast = COORD_W'(V_ACTIVE - 1);

  logic               byte_evt;
  logic [7:0]         byte_data;
  logic               byte_rsel;

  state_t             state_q;
  logic               coord_is_y_q;
  logic [7:0]         lo_q;
  logic [7:0]         r_q;
  logic [7:0]         g_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;

  logic               valid_q;
  logic [COORD_W-1:0] pix_x_q;
  logic [COORD_W-1:0] pix_y_q;
  rgb_t               pix_rgb_q;

  logic               hs;
  logic [COORD_W-1:0] x_adv;
  logic [COORD_W-1:0] y_adv;
  logic [COORD_W-1:0] coord_val;

`ifdef MICRO_RX_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] to_cnt_q;
`endif

  micro_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (Clk),
    .rst_n    (Reset),
    .write    (fpga_write),
    .rsel     (fpga_rsel),
    .data     (fpga_port_in),
    .byte_evt (byte_evt),
    .byte_data(byte_data),
    .byte_rsel(byte_rsel)
  );

  assign hs        = valid_q & pix.pix_wr_ready;
  assign coord_val = {byte_data[COORD_W-9:0], lo_q};

  // Cursor as it will be after this cycle's handshake, so a pixel loaded in the
  // same cycle as a retirement picks up the advanced position.
  always_comb begin
    x_adv = x_q;
    y_adv = y_q;
    if (hs) begin
      if (x_q == XLast) begin
        x_adv = '0;
        y_adv = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_adv = x_q + 1'b1;
      end
    end
  end

  // Decoder FSM, cursor, pixel output register and sticky status flags.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= StIdle;
      coord_is_y_q <= 1'b0;
      lo_q         <= '0;
      r_q          <= '0;
      g_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      valid_q      <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      cmd_err      <= 1'b0;
      ovf_err      <= 1'b0;
      rx_activity  <= 1'b0;
`ifdef MICRO_RX_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      if (hs) begin
        valid_q <= 1'b0;
        x_q     <= x_adv;
        y_q     <= y_adv;
      end

      if (byte_evt) begin
        rx_activity <= ~rx_activity;
        if (!byte_rsel) begin
          // Command bytes abort any sequence and decode as if from idle.
          case (byte_data)
            OP_NOP:          state_q <= StIdle;
            OP_SET_X: begin
              state_q      <= StCoordLo;
              coord_is_y_q <= 1'b0;
            end
            OP_SET_Y: begin
              state_q      <= StCoordLo;
              coord_is_y_q <= 1'b1;
            end
            OP_WRITE_PIXELS: state_q <= StPixR;
            OP_CLR_STATUS: begin
              state_q <= StIdle;
              cmd_err <= 1'b0;
              ovf_err <= 1'b0;
            end
            default: begin
              state_q <= StIdle;
              cmd_err <= 1'b1;
            end
          endcase
        end else begin
          case (state_q)
            StIdle: cmd_err <= 1'b1;
            StCoordLo: begin
              lo_q    <= byte_data;
              state_q <= StCoordHi;
            end
            StCoordHi: begin
              state_q <= StIdle;
              if (coord_is_y_q) begin
                if (coord_val <= YLast) y_q <= coord_val;
                else cmd_err <= 1'b1;
              end else begin
                if (coord_val <= XLast) x_q <= coord_val;
                else cmd_err <= 1'b1;
              end
            end
            StPixR: begin
              r_q     <= byte_data;
              state_q <= StPixG;
            end
            StPixG: begin
              g_q     <= byte_data;
              state_q <= StPixB;
            end
            StPixB: begin
              state_q <= StPixR;
              if (!valid_q || hs) begin
                valid_q   <= 1'b1;
                pix_x_q   <= x_adv;
                pix_y_q   <= y_adv;
                pix_rgb_q <= '{r: r_q, g: g_q, b: byte_data};
              end else begin
                ovf_err <= 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end

`ifdef MICRO_RX_TIMEOUT_EN
      if (byte_evt) begin
        to_cnt_q <= '0;
      end else if (state_q inside {StCoordLo, StCoordHi, StPixG, StPixB}) begin
        if (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_q <= '0;
          cmd_err  <= 1'b1;
          state_q  <= (state_q inside {StPixG, StPixB}) ? StPixR : StIdle;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
`endif
    end
  end

  assign busy             = (state_q != StIdle);
  assign pix.pix_wr_valid = valid_q;
  assign pix.pix_x        = pix_x_q;
  assign pix.pix_y        = pix_y_q;
  assign pix.pix_rgb      = pix_rgb_q;

endmodule

// File: tb/tb_micro_port_rx.sv
// Scoreboard bench for micro_port_rx: stimulus pushes expected pixels, a monitor
// pops and compares on every accepted handshake.
module tb_micro_port_rx;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] fpga_port_in = 8'h00;
  logic       fpga_rsel = 1'b0;
  logic       fpga_write = 1'b0;
  logic       busy, cmd_err, ovf_err, rx_activity;

  int errors = 0;
  int checks = 0;
  int bytes_sent = 0;

  typedef struct {
    int         x;
    int         y;
    logic [23:0] rgb;
  } pix_t;

  pix_t exp_q[$];

  micro_port_rx_if #(.COORD_W(10)) pix_if ();

  micro_port_rx #(
    .SYNC_STAGES(2),
    .H_ACTIVE   (480),
    .V_ACTIVE   (272),
    .COORD_W    (10)
`ifdef MICRO_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .fpga_port_in(fpga_port_in),
    .fpga_rsel   (fpga_rsel),
    .fpga_write  (fpga_write),
    .pix         (pix_if.master),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .ovf_err     (ovf_err),
    .rx_activity (rx_activity)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic rsel, input logic [7:0] data);
    @(negedge Clk);
    fpga_rsel    = rsel;
    fpga_port_in = data;
    repeat (2) @(negedge Clk);
    fpga_write = 1'b1;
    repeat (6) @(negedge Clk);
    fpga_write = 1'b0;
    repeat (6) @(negedge Clk);
    bytes_sent++;
  endtask

  task automatic cmd(input logic [7:0] op);
    send_byte(1'b0, op);
  endtask

  task automatic dat(input logic [7:0] d);
    send_byte(1'b1, d);
  endtask

  task automatic send_rgb(input logic [23:0] rgb);
    dat(rgb[23:16]);
    dat(rgb[15:8]);
    dat(rgb[7:0]);
  endtask

  task automatic push_exp(input int x, input int y, input logic [23:0] rgb);
    pix_t p;
    p.x   = x;
    p.y   = y;
    p.rgb = rgb;
    exp_q.push_back(p);
  endtask

  // Monitor: every accepted pixel must match the oldest expected entry.
  always @(negedge Clk) begin
    if (Reset && pix_if.pix_wr_valid && pix_if.pix_wr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel", {12'h0, pix_if.pix_x, pix_if.pix_y}, 32'hFFFF_FFFF);
      end else begin
        pix_t p;
        p = exp_q.pop_front();
        chk("pix_x", 32'(pix_if.pix_x), 32'(p.x));
        chk("pix_y", 32'(pix_if.pix_y), 32'(p.y));
        chk("pix_rgb", 32'(pix_if.pix_rgb), 32'(p.rgb));
      end
    end
  end

  initial begin
    int waited;
    pix_if.pix_wr_ready = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_valid", 32'(pix_if.pix_wr_valid), 0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_ovf_err", 32'(ovf_err), 0);
    chk("rst_rx_act", 32'(rx_activity), 0);

    // T1: set X = 300, Y = 16
    cmd(8'h01);
    chk("t1_busy_coord", 32'(busy), 1);
    dat(8'h2C);
    dat(8'h01);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_cmd_err", 32'(cmd_err), 0);
    cmd(8'h02);
    dat(8'h10);
    dat(8'h00);
    chk("t1_rx_act", 32'(rx_activity), 32'(bytes_sent % 2));

    // T2: single pixel at (300,16)
    cmd(8'h03);
    chk("t2_busy_pixr", 32'(busy), 1);
    push_exp(300, 16, 24'hAABBCC);
    send_rgb(24'hAABBCC);
    cmd(8'h00);
    chk("t2_busy_nop", 32'(busy), 0);

    // T3: wrap from bottom-right corner to origin
    cmd(8'h01); dat(8'hDF); dat(8'h01);
    cmd(8'h02); dat(8'h0F); dat(8'h01);
    cmd(8'h03);
    push_exp(479, 271, 24'h112233);
    push_exp(0, 0, 24'h445566);
    send_rgb(24'h112233);
    send_rgb(24'h445566);
    cmd(8'h00);

    // T4: consumer stalled; second pixel is dropped
    pix_if.pix_wr_ready = 1'b0;
    cmd(8'h03);
    push_exp(1, 0, 24'h010203);
    send_rgb(24'h010203);
    send_rgb(24'h040506);
    chk("t4_ovf_err", 32'(ovf_err), 1);
    chk("t4_held_valid", 32'(pix_if.pix_wr_valid), 1);
    chk("t4_held_rgb", 32'(pix_if.pix_rgb), 32'h010203);
    chk("t4_held_x", 32'(pix_if.pix_x), 1);
    pix_if.pix_wr_ready = 1'b1;
    repeat (3) @(negedge Clk);
    chk("t4_valid_retired", 32'(pix_if.pix_wr_valid), 0);
    cmd(8'h05);
    chk("t4_ovf_clr", 32'(ovf_err), 0);

    // T5: out-of-range coordinates, unknown opcode, stray data
    cmd(8'h01); dat(8'hF0); dat(8'h01);
    chk("t5_x_range_err", 32'(cmd_err), 1);
    cmd(8'h05);
    cmd(8'h02); dat(8'h10); dat(8'h01);
    chk("t5_y_range_err", 32'(cmd_err), 1);
    cmd(8'h05);
    chk("t5_clr", 32'(cmd_err), 0);
    cmd(8'h03);
    push_exp(2, 0, 24'h778899);
    send_rgb(24'h778899);
    cmd(8'h7E);
    chk("t5_bad_op_err", 32'(cmd_err), 1);
    chk("t5_bad_op_idle", 32'(busy), 0);
    cmd(8'h05);
    dat(8'h55);
    chk("t5_stray_data_err", 32'(cmd_err), 1);
    chk("t5_rx_act", 32'(rx_activity), 32'(bytes_sent % 2));

    // T6: reset in the middle of a pixel
    cmd(8'h03);
    dat(8'h11);
    chk("t6_busy_pixg", 32'(busy), 1);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    bytes_sent = 0;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cmd_err", 32'(cmd_err), 0);
    chk("t6_rst_rx_act", 32'(rx_activity), 0);
    chk("t6_rst_valid", 32'(pix_if.pix_wr_valid), 0);
    chk("t6_rst_rgb", 32'(pix_if.pix_rgb), 0);
    Reset = 1'b1;
    cmd(8'h03);
    push_exp(0, 0, 24'hDDEEFF);
    send_rgb(24'hDDEEFF);

`ifdef MICRO_RX_TIMEOUT_EN
    // Stall in PIX_G until the timeout returns the FSM to PIX_R
    dat(8'h01);
    repeat (84) @(negedge Clk);
    chk("to_cmd_err", 32'(cmd_err), 1);
    chk("to_busy_pixr", 32'(busy), 1);
    push_exp(1, 0, 24'h203040);
    send_rgb(24'h203040);
`endif
    cmd(8'h00);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    chk("drain_expected", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
